lcd_timing_gen: RTL and testbench

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

---
 rtl/lcd_timing_pkg.sv | 56 +++++
 rtl/lcd_timing_lut.sv | 24 ++
 rtl/lcd_timing_gen.sv | 118 +++++++++++
 tb/tb_lcd_timing_gen.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - panel IDs and timing sets shared by the LCD timing generator
package lcd_timing_pkg;

   localparam logic [15:0] ID_4342 = 16'h4342;
   localparam logic [15:0] ID_7084 = 16'h7084;
   localparam logic [15:0] ID_7016 = 16'h7016;
   localparam logic [15:0] ID_4384 = 16'h4384;
   localparam logic [15:0] ID_1018 = 16'h1018;

   typedef struct packed {
      logic [10:0] hsync;
      logic [10:0] hbp;
      logic [10:0] hdisp;
      logic [10:0] htotal;
      logic [10:0] vsync;
      logic [10:0] vbp;
      logic [10:0] vdisp;
      logic [10:0] vtotal;
   } lcd_timing_t;

   localparam lcd_timing_t TIMING_NONE = '0;

   localparam lcd_timing_t TIMING_4342 = '{
      hsync: 11'd41,  hbp: 11'd2,   hdisp: 11'd480,  htotal: 11'd525,
      vsync: 11'd10,  vbp: 11'd2,   vdisp: 11'd272,  vtotal: 11'd286
   };

   localparam lcd_timing_t TIMING_7084 = '{
      hsync: 11'd128, hbp: 11'd88,  hdisp: 11'd800,  htotal: 11'd1056,
      vsync: 11'd2,   vbp: 11'd33,  vdisp: 11'd480,  vtotal: 11'd525
   };

   localparam lcd_timing_t TIMING_7016 = '{
      hsync: 11'd20,  hbp: 11'd140, hdisp: 11'd1024, htotal: 11'd1344,
      vsync: 11'd3,   vbp: 11'd20,  vdisp: 11'd600,  vtotal: 11'd635
   };

   localparam lcd_timing_t TIMING_4384 = '{
      hsync: 11'd128, hbp: 11'd88,  hdisp: 11'd800,  htotal: 11'd1056,
      vsync: 11'd2,   vbp: 11'd33,  vdisp: 11'd480,  vtotal: 11'd525
   };

   localparam lcd_timing_t TIMING_1018 = '{
      hsync: 11'd10,  hbp: 11'd80,  hdisp: 11'd1280, htotal: 11'd1440,
      vsync: 11'd3,   vbp: 11'd10,  vdisp: 11'd800,  vtotal: 11'd823
   };

   // Backlight follows the incoming ID, so validity is needed without the full table.
   function automatic logic id_valid(input logic [15:0] id);
      case (id)
         ID_4342, ID_7084, ID_7016, ID_4384, ID_1018: id_valid = 1'b1;
         default:                                     id_valid = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lcd_timing_lut.sv
// rtl/lcd_timing_lut.sv - combinational panel ID to timing set decode
module lcd_timing_lut
   import lcd_timing_pkg::*;
(
   input  logic [15:0]  i_lcd_id,
   output lcd_timing_t  o_timing,
   output logic         o_valid
);

   // Unknown IDs give an all-zero set so h_disp/v_disp read 0 downstream.
   always_comb begin
      o_timing = TIMING_NONE;
      o_valid  = 1'b0;
      case (i_lcd_id)
         ID_4342: begin o_timing = TIMING_4342; o_valid = 1'b1; end
         ID_7084: begin o_timing = TIMING_7084; o_valid = 1'b1; end
         ID_7016: begin o_timing = TIMING_7016; o_valid = 1'b1; end
         ID_4384: begin o_timing = TIMING_4384; o_valid = 1'b1; end
         ID_1018: begin o_timing = TIMING_1018; o_valid = 1'b1; end
         default: begin o_timing = TIMING_NONE; o_valid = 1'b0; end
      endcase
   end

endmodule

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - RGB LCD sync/data-enable generator with per-panel timing
module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int PIX_W = 24
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      lcd_id,
   input  logic [PIX_W-1:0] pixel_data,
   output logic             data_req,
   output logic [10:0]      pixel_xpos,
   output logic [10:0]      pixel_ypos,
   output logic [10:0]      h_disp,
   output logic [10:0]      v_disp,
   output logic             lcd_hs,
   output logic             lcd_vs,
   output logic             lcd_de,
   output logic [PIX_W-1:0] lcd_rgb,
   output logic             lcd_bl
);

   logic [15:0]      r_lcd_id;
   logic [10:0]      r_h_cnt;
   logic [10:0]      r_v_cnt;
   logic             r_de;
   logic [PIX_W-1:0] r_rgb;
   logic             r_hs;
   logic             r_vs;
   logic             r_bl;

   lcd_timing_t      w_tim;
   logic             w_valid;
   logic             w_id_change;
   logic             w_h_last;
   logic             w_v_last;
   logic [10:0]      w_h_start;
   logic [10:0]      w_h_end;
   logic [10:0]      w_v_start;
   logic [10:0]      w_v_end;
   logic             w_h_active;
   logic             w_v_active;

   // The table follows the registered ID so a new panel starts from a cleared frame.
   lcd_timing_lut u_lut (
      .i_lcd_id (r_lcd_id),
      .o_timing (w_tim),
      .o_valid  (w_valid)
   );

   assign w_id_change = (r_lcd_id != lcd_id);
   assign w_h_last    = (r_h_cnt == w_tim.htotal - 11'd1);
   assign w_v_last    = (r_v_cnt == w_tim.vtotal - 11'd1);

   // Request window opens one column early to cover the pixel_data fetch latency.
   assign w_h_start   = w_tim.hsync + w_tim.hbp - 11'd1;
   assign w_h_end     = w_h_start + w_tim.hdisp;
   assign w_v_start   = w_tim.vsync + w_tim.vbp;
   assign w_v_end     = w_v_start + w_tim.vdisp;

   assign w_h_active  = (r_h_cnt >= w_h_start) && (r_h_cnt < w_h_end);
   assign w_v_active  = (r_v_cnt >= w_v_start) && (r_v_cnt < w_v_end);

   assign data_req    = w_valid && w_h_active && w_v_active;
   assign pixel_xpos  = data_req ? (r_h_cnt - w_h_start) : 11'd0;
   assign pixel_ypos  = data_req ? (r_v_cnt - w_v_start) : 11'd0;
   assign h_disp      = w_tim.hdisp;
   assign v_disp      = w_tim.vdisp;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lcd_id <= 16'd0;
         r_h_cnt  <= 11'd0;
         r_v_cnt  <= 11'd0;
      end else begin
         r_lcd_id <= lcd_id;
         if (w_id_change || !w_valid) begin
            r_h_cnt <= 11'd0;
            r_v_cnt <= 11'd0;
         end else if (w_h_last) begin
            r_h_cnt <= 11'd0;
            r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
         end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
         end
      end
   end

   // An ID switch idles the panel pins for one cycle so no stale pixel leaks out.
   always_ff @(posedge clk) begin
      if (!rst_n || w_id_change) begin
         r_de  <= 1'b0;
         r_rgb <= '0;
         r_hs  <= 1'b1;
         r_vs  <= 1'b1;
      end else begin
         r_de  <= data_req;
         r_rgb <= data_req ? pixel_data : '0;
         r_hs  <= ~(r_h_cnt < w_tim.hsync);
         r_vs  <= ~(r_v_cnt < w_tim.vsync);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bl <= 1'b0;
      end else begin
         r_bl <= id_valid(lcd_id);
      end
   end

   assign lcd_de  = r_de;
   assign lcd_rgb = r_rgb;
   assign lcd_hs  = r_hs;
   assign lcd_vs  = r_vs;
   assign lcd_bl  = r_bl;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - self-checking bench for lcd_timing_gen
module tb_lcd_timing_gen;

   localparam int PIX_W = 24;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [15:0]      lcd_id;
   logic [PIX_W-1:0] pixel_data;
   logic             data_req;
   logic [10:0]      pixel_xpos;
   logic [10:0]      pixel_ypos;
   logic [10:0]      h_disp;
   logic [10:0]      v_disp;
   logic             lcd_hs;
   logic             lcd_vs;
   logic             lcd_de;
   logic [PIX_W-1:0] lcd_rgb;
   logic             lcd_bl;

   always #5 clk = ~clk;

   lcd_timing_gen #(.PIX_W(PIX_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lcd_id     (lcd_id),
      .pixel_data (pixel_data),
      .data_req   (data_req),
      .pixel_xpos (pixel_xpos),
      .pixel_ypos (pixel_ypos),
      .h_disp     (h_disp),
      .v_disp     (v_disp),
      .lcd_hs     (lcd_hs),
      .lcd_vs     (lcd_vs),
      .lcd_de     (lcd_de),
      .lcd_rgb    (lcd_rgb),
      .lcd_bl     (lcd_bl)
   );

   typedef struct {
      int hs; int hbp; int hd; int ht;
      int vs; int vbp; int vd; int vt;
      bit ok;
   } tim_t;

   typedef struct {
      bit               de;
      logic [PIX_W-1:0] rgb;
      bit               hs;
      bit               vs;
      bit               bl;
   } exp_t;

   typedef struct {
      logic [15:0] id;
      int          hd;
      int          vd;
      int          bl;
      int          hs_low;
      int          win;
   } vec_t;

   exp_t        sb_q[$];
   vec_t        vecs[8];
   logic [15:0] m_id;
   int          m_pos;
   bit          mode;
   int          n_cmp;
   int          n_bad;
   int          sb_err;

   function automatic tim_t tim_of(input logic [15:0] id);
      tim_t t;
      t = '{default: 0};
      case (id)
         16'h4342: t = '{41, 2, 480, 525, 10, 2, 272, 286, 1'b1};
         16'h7084: t = '{128, 88, 800, 1056, 2, 33, 480, 525, 1'b1};
         16'h7016: t = '{20, 140, 1024, 1344, 3, 20, 600, 635, 1'b1};
         16'h4384: t = '{128, 88, 800, 1056, 2, 33, 480, 525, 1'b1};
         16'h1018: t = '{10, 80, 1280, 1440, 3, 10, 800, 823, 1'b1};
         default:  t = '{default: 0};
      endcase
      return t;
   endfunction

   task automatic check(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   // One clock: compare combinational outputs, queue the registered expectation, pop it after the edge.
   task automatic step();
      tim_t t;
      tim_t tn;
      int   h;
      int   v;
      int   h0;
      int   v0;
      bit   req;
      int   xp;
      int   yp;
      exp_t e;
      exp_t w;
      t   = tim_of(m_id);
      h   = t.ok ? m_pos % t.ht : 0;
      v   = t.ok ? m_pos / t.ht : 0;
      h0  = t.hs + t.hbp - 1;
      v0  = t.vs + t.vbp;
      req = t.ok && (h >= h0) && (h < h0 + t.hd) && (v >= v0) && (v < v0 + t.vd);
      xp  = req ? h - h0 : 0;
      yp  = req ? v - v0 : 0;
      pixel_data = mode ? PIX_W'(pixel_xpos) : PIX_W'($urandom);
      if (data_req !== req || int'(pixel_xpos) != xp || int'(pixel_ypos) != yp ||
          int'(h_disp) != t.hd || int'(v_disp) != t.vd)
         sb_err++;
      e.de = 1'b0; e.rgb = '0; e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0;
      if (!rst_n) begin
         m_id  = 16'd0;
         m_pos = 0;
      end else if (m_id !== lcd_id) begin
         tn    = tim_of(lcd_id);
         e.bl  = tn.ok;
         m_id  = lcd_id;
         m_pos = 0;
      end else if (t.ok) begin
         e.de  = req;
         e.rgb = req ? (mode ? PIX_W'(xp) : pixel_data) : '0;
         e.hs  = !(h < t.hs);
         e.vs  = !(v < t.vs);
         e.bl  = 1'b1;
         m_pos = (m_pos + 1) % (t.ht * t.vt);
      end
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      w = sb_q.pop_front();
      if (lcd_de !== w.de || lcd_rgb !== w.rgb || lcd_hs !== w.hs ||
          lcd_vs !== w.vs || lcd_bl !== w.bl)
         sb_err++;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_de"},  int'(lcd_de),  0);
      check({tag, "_rgb"}, int'(lcd_rgb), 0);
      check({tag, "_hs"},  int'(lcd_hs),  1);
      check({tag, "_vs"},  int'(lcd_vs),  1);
      check({tag, "_bl"},  int'(lcd_bl),  0);
      check({tag, "_req"}, int'(data_req), 0);
      check({tag, "_hdisp"}, int'(h_disp), 0);
   endtask

   initial begin
      int hs_cnt, de_cnt, de_l12, vs_cnt, first_de, fall1, fall2;
      int n_rgb, first_rgb, last_rgb, prev_rgb, seq_err;
      int ph, pv, hh, vv;
      bit wrapped;

      n_cmp = 0; n_bad = 0; sb_err = 0;
      m_id = 16'd0; m_pos = 0; mode = 1'b0;
      rst_n = 1'b0; lcd_id = 16'h4342; pixel_data = '0;

      vecs[0] = '{16'h4342, 480,  272, 1, 41,  525};
      vecs[1] = '{16'h7084, 800,  480, 1, 128, 1056};
      vecs[2] = '{16'h7016, 1024, 600, 1, 20,  1344};
      vecs[3] = '{16'h4384, 800,  480, 1, 128, 1056};
      vecs[4] = '{16'h1018, 1280, 800, 1, 10,  1440};
      vecs[5] = '{16'h0000, 0,    0,   0, 0,   16};
      vecs[6] = '{16'hFFFF, 0,    0,   0, 0,   16};
      vecs[7] = '{16'h4343, 0,    0,   0, 0,   16};

      @(negedge clk);
      step();
      step();
      check_idle("reset");

      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         lcd_id = vecs[i].id;
         step();
         hs_cnt = 0; de_cnt = 0;
         for (int k = 1; k <= vecs[i].win; k++) begin
            step();
            if (!lcd_hs) hs_cnt++;
            if (lcd_de)  de_cnt++;
         end
         check($sformatf("vec%0d_hdisp", i), int'(h_disp), vecs[i].hd);
         check($sformatf("vec%0d_vdisp", i), int'(v_disp), vecs[i].vd);
         check($sformatf("vec%0d_bl", i),    int'(lcd_bl), vecs[i].bl);
         check($sformatf("vec%0d_hs_low", i), hs_cnt, vecs[i].hs_low);
         check($sformatf("vec%0d_line0_de", i), de_cnt, 0);
      end

      // 4342 frame start: first de lands on h_cnt=43, v_cnt=12
      lcd_id = 16'h4342;
      step();
      first_de = -1; de_cnt = 0; de_l12 = 0; fall1 = -1; fall2 = -1;
      for (int k = 1; k <= 14 * 525; k++) begin
         ph = int'(lcd_hs);
         step();
         if (lcd_de) begin
            de_cnt++;
            if (first_de < 0) first_de = k;
            if (k > 12 * 525 && k <= 13 * 525) de_l12++;
         end
         if (ph == 1 && !lcd_hs) begin
            if (fall1 < 0) fall1 = k;
            else if (fall2 < 0) fall2 = k;
         end
      end
      check("first_de_pos", first_de, 12 * 525 + 43);
      check("de_per_line", de_l12, 480);
      check("de_two_lines", de_cnt, 960);
      check("line_period", fall2 - fall1, 525);

      for (int k = 0; k < 100; k++) step();
      check("pre_reset_de", int'(lcd_de), 1);
      rst_n = 1'b0;
      step();
      check_idle("midline_rst");

      // 7084 with pixel_data echoing pixel_xpos
      rst_n = 1'b1; lcd_id = 16'h7084; mode = 1'b1;
      step();
      vs_cnt = 0; hs_cnt = 0; n_rgb = 0; first_rgb = -1; last_rgb = -1; prev_rgb = -1; seq_err = 0;
      for (int k = 1; k <= 36 * 1056 + 2; k++) begin
         step();
         if (!lcd_vs) vs_cnt++;
         if (!lcd_hs && k <= 1056) hs_cnt++;
         if (lcd_de) begin
            if (n_rgb == 0) first_rgb = int'(lcd_rgb);
            else if (int'(lcd_rgb) != prev_rgb + 1) seq_err++;
            prev_rgb = int'(lcd_rgb);
            last_rgb = int'(lcd_rgb);
            n_rgb++;
         end
      end
      check("vs_low_clk", vs_cnt, 2112);
      check("hs_low_7084", hs_cnt, 128);
      check("rgb_count", n_rgb, 800);
      check("rgb_first", first_rgb, 0);
      check("rgb_last", last_rgb, 799);
      check("rgb_seq_err", seq_err, 0);
      mode = 1'b0;

      // Mid-frame panel switch 4342 -> 7016
      lcd_id = 16'h4342;
      step();
      for (int k = 0; k < 12 * 525 + 200; k++) step();
      check("pre_switch_de", int'(lcd_de), 1);
      lcd_id = 16'h7016;
      step();
      check("switch_hcnt", int'(dut.r_h_cnt), 0);
      check("switch_vcnt", int'(dut.r_v_cnt), 0);
      check("switch_de", int'(lcd_de), 0);
      check("switch_hdisp", int'(h_disp), 1024);
      check("switch_vdisp", int'(v_disp), 600);
      for (int k = 0; k < 5; k++) step();
      check("after_switch_hcnt", int'(dut.r_h_cnt), 5);
      check("after_switch_hdisp", int'(h_disp), 1024);

      // 1018 end-of-frame wrap, counters preset near their maxima
      lcd_id = 16'h1018;
      step();
      for (int k = 0; k < 3; k++) step();
      force dut.r_h_cnt = 11'd1430;
      force dut.r_v_cnt = 11'd822;
      #1;
      release dut.r_h_cnt;
      release dut.r_v_cnt;
      m_pos = 822 * 1440 + 1430;
      ph = 1430; pv = 822; wrapped = 1'b0; de_cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         hh = int'(dut.r_h_cnt);
         vv = int'(dut.r_v_cnt);
         if (hh == 0 && !wrapped) begin
            wrapped = 1'b1;
            check("wrap_h_prev", ph, 1439);
            check("wrap_v_prev", pv, 822);
            check("wrap_v_new", vv, 0);
         end
         if (lcd_de) de_cnt++;
         ph = hh; pv = vv;
      end
      check("wrap_seen", int'(wrapped), 1);
      check("wrap_de", de_cnt, 0);

      lcd_id = 16'h0000;
      step();
      check_idle("id_zero");
      step();
      check_idle("id_zero_hold");

      check("scoreboard_errors", sb_err, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
